updown_counter_param: RTL and testbench



---
 rtl/updown_counter_param_pkg.sv | 13 +
 rtl/updown_counter_param.sv | 139 +++++++++++++
 tb/tb_updown_counter_param.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/updown_counter_param_pkg.sv
// Shared constants for the parametrised up/down counter and the timer blocks
// built on top of it: limit-handling modes and count-direction encodings.
package updown_counter_param_pkg;

    // Limit-handling mode, used as the SATURATE parameter value
    localparam int unsigned MODE_WRAP = 32'd0;
    localparam int unsigned MODE_SAT  = 32'd1;

    // Count direction, as seen on the up_dn port
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage : updown_counter_param_pkg

// File: rtl/updown_counter_param.sv
// Parametrised up/down tick counter with modulus, parallel load, wrap or
// saturate limit handling, terminal count, one-cycle limit pulse and a
// sticky overflow flag. All state updates on the rising edge of clk.
module updown_counter_param
    import updown_counter_param_pkg::*;
#(
    parameter int unsigned       WIDTH     = 8,
    parameter logic [32:0]       MODULUS   = 33'd1 << WIDTH,
    parameter int unsigned       SATURATE  = MODE_WRAP,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    // Largest legal count, kept one bit wider than the counter so that a
    // full 2**WIDTH modulus never relies on silent rollover.
    localparam logic [32:0]    MAX_WIDE  = MODULUS - 33'd1;
    localparam logic [WIDTH:0] MAX_C     = MAX_WIDE[WIDTH:0];
    localparam logic [32:0]    RV_WIDE   = {{(33-WIDTH){1'b0}}, RESET_VAL};
    localparam logic [32:0]    FULL_MOD  = 33'd1 << WIDTH;

    // Elaboration-time legality checks on the configuration
    generate
        if (WIDTH < 32'd2 || WIDTH > 32'd32) begin : g_bad_width
            $error("updown_counter_param: WIDTH must be in 2..32");
        end
        if (MODULUS < 33'd2 || MODULUS > FULL_MOD) begin : g_bad_modulus
            $error("updown_counter_param: MODULUS must be in 2..2**WIDTH");
        end
        if (RV_WIDE >= MODULUS) begin : g_bad_reset_val
            $error("updown_counter_param: RESET_VAL must be below MODULUS");
        end
    endgenerate

    logic [WIDTH-1:0] count_r;
    logic             wrap_r;
    logic             ovf_r;

    logic [WIDTH:0]   count_ext_s;
    logic [WIDTH:0]   load_ext_s;
    logic [WIDTH:0]   count_inc_s;
    logic [WIDTH:0]   count_dec_s;
    logic [WIDTH-1:0] count_nxt_s;
    logic             limit_s;
    logic             ovf_nxt_s;

    assign count_ext_s = {1'b0, count_r};
    assign load_ext_s  = {1'b0, load_val};
    assign count_inc_s = count_ext_s + {{WIDTH{1'b0}}, 1'b1};
    assign count_dec_s = count_ext_s - {{WIDTH{1'b0}}, 1'b1};

    // Next count, limit-event detection and overflow flag update
    always_comb begin
        count_nxt_s = count_r;
        limit_s     = 1'b0;
        ovf_nxt_s   = ovf_r;

        if (load) begin
            // Out-of-range load values clamp to the top of the count range
            if (load_ext_s > MAX_C) begin
                count_nxt_s = MAX_C[WIDTH-1:0];
            end else begin
                count_nxt_s = load_val;
            end
        end else if (enable) begin
            if (up_dn == DIR_UP) begin
                if (count_ext_s == MAX_C) begin
                    limit_s = 1'b1;
                    if (SATURATE == MODE_SAT) begin
                        count_nxt_s = count_r;
                    end else begin
                        count_nxt_s = {WIDTH{1'b0}};
                    end
                end else begin
                    count_nxt_s = count_inc_s[WIDTH-1:0];
                end
            end else begin
                if (count_r == {WIDTH{1'b0}}) begin
                    limit_s = 1'b1;
                    if (SATURATE == MODE_SAT) begin
                        count_nxt_s = count_r;
                    end else begin
                        count_nxt_s = MAX_C[WIDTH-1:0];
                    end
                end else begin
                    count_nxt_s = count_dec_s[WIDTH-1:0];
                end
            end
        end else begin
            count_nxt_s = count_r;
        end

        // A coincident limit event wins over a clear request
        if (limit_s) begin
            ovf_nxt_s = 1'b1;
        end else if (ovf_clr) begin
            ovf_nxt_s = 1'b0;
        end else begin
            ovf_nxt_s = ovf_r;
        end
    end

    // Single register stage for count, limit pulse and sticky overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= RESET_VAL;
            wrap_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            wrap_r  <= limit_s;
            ovf_r   <= ovf_nxt_s;
        end
    end

    // Terminal count follows the registered count and the live direction
    always_comb begin
        if (up_dn == DIR_UP) begin
            tc = (count_ext_s == MAX_C);
        end else begin
            tc = (count_r == {WIDTH{1'b0}});
        end
    end

    assign count = count_r;
    assign wrap  = wrap_r;
    assign ovf   = ovf_r;

endmodule : updown_counter_param

// File: tb/tb_updown_counter_param.sv
// Directed, table-driven bench for updown_counter_param with MODULUS=200
// in both wrap and saturate configurations.
module tb_updown_counter_param;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       up_dn;
    logic       load;
    logic [7:0] load_val;
    logic       ovf_clr;

    logic [7:0] count_w;
    logic       tc_w;
    logic       wrap_w;
    logic       ovf_w;
    logic [7:0] count_s;
    logic       tc_s;
    logic       wrap_s;
    logic       ovf_s;

    int checks;
    int failures;

    updown_counter_param #(
        .WIDTH(8), .MODULUS(33'd200), .SATURATE(0), .RESET_VAL(8'd0)
    ) dut_w (
        .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn),
        .load(load), .load_val(load_val), .ovf_clr(ovf_clr),
        .count(count_w), .tc(tc_w), .wrap(wrap_w), .ovf(ovf_w)
    );

    updown_counter_param #(
        .WIDTH(8), .MODULUS(33'd200), .SATURATE(1), .RESET_VAL(8'd0)
    ) dut_s (
        .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn),
        .load(load), .load_val(load_val), .ovf_clr(ovf_clr),
        .count(count_s), .tc(tc_s), .wrap(wrap_s), .ovf(ovf_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       reset;
        logic       enable;
        logic       up_dn;
        logic       load;
        logic [7:0] load_val;
        logic       ovf_clr;
        logic [7:0] exp_count;
        logic       exp_tc;
        logic       exp_wrap;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic en, input logic ud,
                         input logic ld, input logic [7:0] lv, input logic oc);
        reset = r; enable = en; up_dn = ud; load = ld; load_val = lv; ovf_clr = oc;
    endtask

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_w(input string name, input int idx, input logic [7:0] c,
                         input logic t, input logic w, input logic o);
        chk({name, "_count"}, idx, 32'(count_w), 32'(c));
        chk({name, "_tc"},    idx, 32'(tc_w),    32'(t));
        chk({name, "_wrap"},  idx, 32'(wrap_w),  32'(w));
        chk({name, "_ovf"},   idx, 32'(ovf_w),   32'(o));
    endtask

    task automatic chk_s(input string name, input int idx, input logic [7:0] c,
                         input logic t, input logic w, input logic o);
        chk({name, "_count"}, idx, 32'(count_s), 32'(c));
        chk({name, "_tc"},    idx, 32'(tc_s),    32'(t));
        chk({name, "_wrap"},  idx, 32'(wrap_s),  32'(w));
        chk({name, "_ovf"},   idx, 32'(ovf_s),   32'(o));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);

        //            rst   en    ud    ld    lv      clr   count   tc    wrap  ovf
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'd0,   1'b0, 8'd0,   1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd250, 1'b0, 8'd199, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd10,  1'b0, 8'd10,  1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd0,   1'b0, 8'd11,  1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0,   1'b0, 8'd10,  1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd0,   1'b0, 8'd0,   1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0,   1'b0, 8'd199, 1'b0, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0,   1'b0, 8'd198, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0,   1'b0, 8'd198, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd199, 1'b0, 8'd199, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd0,   1'b1, 8'd0,   1'b0, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0,   1'b1, 8'd0,   1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd50,  1'b0, 8'd50,  1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd0,   1'b0, 8'd0,   1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd0,   1'b0, 8'd1,   1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd0,   1'b0, 8'd2,   1'b0, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd199, 1'b0, 8'd199, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd0,   1'b0, 8'd0,   1'b0, 1'b1, 1'b1};
        vecs[18] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'd5,   1'b0, 8'd0,   1'b0, 1'b0, 1'b0};

        // Table vectors on the wrap-mode counter
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].reset, vecs[i].enable, vecs[i].up_dn,
                  vecs[i].load, vecs[i].load_val, vecs[i].ovf_clr);
            step();
            chk_w("vec", i, vecs[i].exp_count, vecs[i].exp_tc,
                  vecs[i].exp_wrap, vecs[i].exp_ovf);
        end

        // Long up-count across the 199 -> 0 wrap
        drive(1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
        step();
        chk_w("upseq_rst", 0, 8'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
        for (int i = 1; i <= 205; i++) begin
            logic [7:0] exp_c;
            exp_c = 8'(i % 200);
            step();
            chk_w("upseq", i, exp_c, (exp_c == 8'd199),
                  (i == 200), (i >= 200));
        end

        // Down-count from reset: 0 -> 199 -> 198
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        step();
        chk_w("dnseq", 0, 8'd0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        step();
        chk_w("dnseq", 1, 8'd199, 1'b0, 1'b1, 1'b1);
        step();
        chk_w("dnseq", 2, 8'd198, 1'b0, 1'b0, 1'b1);

        // Saturate mode: load 198, then hold at the upper limit
        drive(1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'd198, 1'b0);
        step();
        chk_s("satup_ld", 0, 8'd198, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk_s("satup", i, 8'd199, 1'b1, (i > 1), (i > 1));
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
        step();
        chk_s("satup_idle", 0, 8'd199, 1'b1, 1'b0, 1'b1);

        // Saturate mode: down-count held at zero
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        step();
        chk_s("satdn", 0, 8'd0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        step();
        chk_s("satdn", 1, 8'd0, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 1'b1);
        step();
        chk_s("satdn", 2, 8'd1, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_updown_counter_param
